// File: rtl/freq_meas_ctrl_if.sv
// Request/result bus of the frequency-meter sequencer: start/config in, count/ratio out with valid/ack.
interface freq_meas_ctrl_if #(
   parameter int unsigned CNT_W = 32
);
   logic             start;
   logic             auto_en;
   logic [1:0]       div_cfg;
   logic             busy;
   logic [CNT_W-1:0] result;
   logic [1:0]       result_div;
   logic             overrange;
   logic             result_valid;
   logic             result_ack;

   modport master (
      output start, auto_en, div_cfg, result_ack,
      input  busy, result, result_div, overrange, result_valid
   );

   modport slave (
      input  start, auto_en, div_cfg, result_ack,
      output busy, result, result_div, overrange, result_valid
   );
endinterface

// File: rtl/freq_meas_ctrl.sv
// Frequency-meter sequencer: arms the prescaler, counts prescaled edges over a fixed gate, auto-ranges.
// Define FREQ_MEAS_CONT_EN for continuous re-measurement after each acknowledge.
module freq_meas_ctrl #(
   parameter int unsigned GATE_CYCLES = 50000000,
   parameter int unsigned CNT_W       = 32,
   parameter int unsigned HI_TH       = 16777216
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_sig_pre,
   output logic [1:0]       o_div_sel,
   output logic             o_pre_rst_n,
   output logic             o_gate,
   freq_meas_ctrl_if.slave  bus
);
   localparam int unsigned     PH_W      = (GATE_CYCLES > 4) ? $clog2(GATE_CYCLES) : 3;
   localparam logic [PH_W-1:0] GATE_LAST = PH_W'(GATE_CYCLES - 1);
   localparam logic [63:0]     HI_TH_W   = 64'(HI_TH);

   typedef enum logic [2:0] {
      S_IDLE, S_ARM, S_GATE, S_SETTLE, S_EVAL, S_DONE
   } state_t;

   state_t           r_state;
   logic [PH_W-1:0]  r_ph;
   logic [2:0]       r_sync;
   logic [1:0]       r_gate_d;
   logic [CNT_W-1:0] r_cnt;
   logic             r_sat;
   logic             r_auto;
   logic [1:0]       r_div_sel;
   logic             r_pre_rst_n;
   logic             r_gate;
   logic             r_busy;
   logic [CNT_W-1:0] r_result;
   logic [1:0]       r_result_div;
   logic             r_ovr;
   logic             r_valid;
`ifdef FREQ_MEAS_CONT_EN
   logic [1:0]       r_cfg;
`endif

   logic w_edge;
   logic w_hi;
   logic w_step;

   // Two synchronizer flops plus one history flop for rising-edge detection
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync   <= '0;
         r_gate_d <= '0;
      end else begin
         r_sync   <= {r_sync[1:0], i_sig_pre};
         r_gate_d <= {r_gate_d[0], r_gate};
      end
   end

   // Window delayed by the synchronizer latency so edges seen during the gate land inside it
   assign w_edge = r_sync[1] & ~r_sync[2] & r_gate_d[1];
   assign w_hi   = (64'(r_cnt) >= HI_TH_W);
   assign w_step = r_auto & (r_sat | w_hi) & (r_div_sel != 2'd3);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_ph         <= '0;
         r_cnt        <= '0;
         r_sat        <= 1'b0;
         r_auto       <= 1'b0;
         r_div_sel    <= 2'd0;
         r_pre_rst_n  <= 1'b0;
         r_gate       <= 1'b0;
         r_busy       <= 1'b0;
         r_result     <= '0;
         r_result_div <= 2'd0;
         r_ovr        <= 1'b0;
         r_valid      <= 1'b0;
`ifdef FREQ_MEAS_CONT_EN
         r_cfg        <= 2'd0;
`endif
      end else begin
         // Saturating edge counter, cleared while armed
         if (r_state == S_ARM) begin
            r_cnt <= '0;
            r_sat <= 1'b0;
         end else if (w_edge) begin
            if (&r_cnt) r_sat <= 1'b1;
            else        r_cnt <= r_cnt + CNT_W'(1);
         end

         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_auto    <= bus.auto_en;
                  r_div_sel <= bus.div_cfg;
`ifdef FREQ_MEAS_CONT_EN
                  r_cfg     <= bus.div_cfg;
`endif
                  r_busy    <= 1'b1;
                  r_ph      <= '0;
                  r_state   <= S_ARM;
               end
            end
            S_ARM: begin
               if (r_ph == PH_W'(1)) begin
                  r_ph        <= '0;
                  r_pre_rst_n <= 1'b1;
                  r_gate      <= 1'b1;
                  r_state     <= S_GATE;
               end else begin
                  r_ph <= r_ph + PH_W'(1);
               end
            end
            S_GATE: begin
               if (r_ph == GATE_LAST) begin
                  r_ph    <= '0;
                  r_gate  <= 1'b0;
                  r_state <= S_SETTLE;
               end else begin
                  r_ph <= r_ph + PH_W'(1);
               end
            end
            S_SETTLE: begin
               if (r_ph == PH_W'(2)) begin
                  r_ph    <= '0;
                  r_state <= S_EVAL;
               end else begin
                  r_ph <= r_ph + PH_W'(1);
               end
            end
            S_EVAL: begin
               r_pre_rst_n <= 1'b0;
               if (w_step) begin
                  r_div_sel <= r_div_sel + 2'd1;
                  r_state   <= S_ARM;
               end else begin
                  r_result     <= r_cnt;
                  r_result_div <= r_div_sel;
                  r_ovr        <= r_sat | (r_auto & w_hi & (r_div_sel == 2'd3));
                  r_valid      <= 1'b1;
                  r_state      <= S_DONE;
               end
            end
            S_DONE: begin
               if (bus.result_ack) begin
                  r_valid <= 1'b0;
`ifdef FREQ_MEAS_CONT_EN
                  r_div_sel <= r_cfg;
                  r_state   <= S_ARM;
`else
                  r_busy    <= 1'b0;
                  r_state   <= S_IDLE;
`endif
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_div_sel        = r_div_sel;
   assign o_pre_rst_n      = r_pre_rst_n;
   assign o_gate           = r_gate;
   assign bus.busy         = r_busy;
   assign bus.result       = r_result;
   assign bus.result_div   = r_result_div;
   assign bus.overrange    = r_ovr;
   assign bus.result_valid = r_valid;
endmodule

// File: doc/freq_meas_ctrl.md
Name: freq_meas_ctrl

Overview:
- Sequencer for the frequency-meter input path. Programs the input prescaler ratio and holds the prescaler in reset between measurements.
- Opens a fixed-length gate on the system clock and counts rising edges of the prescaled signal during the gate.
- Optional auto-ranging: if the count is too large, it raises the division ratio and measures again.
- Presents the count and the ratio used through a valid/ack handshake to the display/compute logic.

Parameters:
- GATE_CYCLES, 50000000: gate length in clk cycles (1 s at 50 MHz).
- CNT_W, 32: width of the edge counter and result.
- HI_TH, 16777216: auto-range step-up threshold (count >= HI_TH steps the ratio up).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-low.
- start  input  1  one-cycle measurement request; accepted only in IDLE.
- auto_en  input  1  1 = auto-range, 0 = use div_cfg only; sampled at start.
- div_cfg  input  2  initial/manual ratio code: 0=/1, 1=/16, 2=/256, 3=/4096; sampled at start.
- sig_pre  input  1  prescaler output, asynchronous to clk.
- div_sel  output  2  ratio code driven to the prescaler.
- pre_rst_n  output  1  active-low prescaler reset.
- gate  output  1  high during the count window.
- busy  output  1  high in every state except IDLE.
- result  output  CNT_W  latched edge count.
- result_div  output  2  ratio code used for result.
- overrange  output  1  count saturated, or HI_TH exceeded at code 3.
- result_valid  output  1  result available.
- result_ack  input  1  consumer acknowledge.

Behaviour:
- Reset values: div_sel=0, pre_rst_n=0, gate=0, busy=0, result=0, result_div=0, overrange=0, result_valid=0. Internal counter, synchronizer and state are cleared. Reset asserted mid-operation aborts immediately, with no partial result.
- Input synchronizer: sig_pre passes through 2 flops, then a rising-edge detector.
- Count window: a copy of gate delayed by 2 cycles (gate_d2). An edge is counted only while gate_d2=1.
- Counter: saturates at all-ones and sets a sat flag; it never wraps.
- States:
  - IDLE: busy=0, pre_rst_n=0. On start, latch auto_en and div_cfg, set div_sel=div_cfg, go to ARM. start in any other state is ignored.
  - ARM: 2 cycles; pre_rst_n=0; clear counter and sat flag. Then go to GATE.
  - GATE: pre_rst_n=1, gate=1 for exactly GATE_CYCLES cycles. Then go to SETTLE.
  - SETTLE: 3 cycles, gate=0, pre_rst_n stays 1. This flushes the synchronizer pipeline so edges from the final gate cycles are counted. Then go to EVAL.
  - EVAL: 1 cycle; decide:
    - If auto and (sat or count>=HI_TH) and div_sel<3: div_sel=div_sel+1, go to ARM (re-measure).
    - Otherwise: result=count, result_div=div_sel, overrange=(sat or (auto and count>=HI_TH and div_sel==3)), go to DONE.
  - DONE: result_valid=1. result, result_div and overrange stay stable until result_ack=1 is sampled. On that ack, clear result_valid next cycle and go to IDLE. result keeps its value after ack.
- Handshake rules:
  - result_ack while result_valid=0 is ignored.
  - start and result_ack asserted in the same cycle in DONE: the ack is honoured and the start is dropped.
- Ranging limits:
  - Auto-ranging only steps upward and stops at code 3. At most 4 gates per request.
  - Manual mode (auto_en=0) always uses exactly one gate.
- Latency: manual request takes 2+GATE_CYCLES+3+1 cycles from start to result_valid. Each auto step adds the same amount.

Optional Feature:
- Macro: FREQ_MEAS_CONT_EN.
- Defined: after result_ack, the block returns to ARM instead of IDLE and re-measures with the same auto_en. The first ARM of each cycle restarts at the latched div_cfg. Measurements repeat until the next reset; start is ignored while busy.
- Undefined: one measurement per start, as described above.

Test Plan:
- Manual count: GATE_CYCLES=1000, auto_en=0, div_cfg=1, bench prescaler model /16 on a source with a 1-clk period. Expect result 62 or 63, result_div=1, overrange=0, result_valid exactly 1006 cycles after start.
- Auto step-up: GATE_CYCLES=1000, HI_TH=200, auto_en=1, div_cfg=0, source period 4 clk. The first gate gives 250 edges, so the block re-arms. Expect final result 15 or 16, result_div=1, 2 gate pulses observed.
- Overrange: HI_TH=10, CNT_W=32, auto_en=1, source period 2 clk, prescaler model applied. Expect result_div=3, overrange=1 after 4 gates.
- Handshake: hold result_ack=0 for 50 cycles after valid, then pulse it. Expect result stable throughout, result_valid=0 the next cycle, busy=0. A start pulsed during GATE produces no second measurement.
- Reset mid-gate: deassert rst at GATE cycle 500. Expect all outputs at reset values immediately. A new start after release gives a full clean result.
- Saturation: CNT_W=4, manual, 40 edges in gate. Expect result=15, overrange=1.
